// File: rtl/dmux8way16_reg_pkg.sv
// Shared constants for the Hack 8-way word distribution blocks (read mux and
// this registered demux), plus a small population-count helper.
package dmux8way16_reg_pkg;

  localparam int HACK_WORD_W = 16;
  localparam int NUM_WAYS    = 8;
  localparam int SEL_W       = $clog2(NUM_WAYS);
  localparam int CNT_W       = $clog2(NUM_WAYS + 1);

  typedef logic [NUM_WAYS-1:0] way_mask_t;
  typedef logic [SEL_W-1:0]    way_sel_t;
  typedef logic [CNT_W-1:0]    way_cnt_t;

  function automatic way_cnt_t popcount_ways(input way_mask_t v);
    way_cnt_t n;
    n = {CNT_W{1'b0}};
    for (int k = 0; k < NUM_WAYS; k++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dmux8way16_reg_dmux8way.sv
// Combinational 1-bit 3-to-8 demultiplexer: routes 'in' to the output
// selected by 'sel'; all other outputs are 0.
import dmux8way16_reg_pkg::*;

module dmux8way (
  input  logic     in,
  input  way_sel_t sel,
  output logic     a,
  output logic     b,
  output logic     c,
  output logic     d,
  output logic     e,
  output logic     f,
  output logic     g,
  output logic     h
);

  way_mask_t w_onehot;

  // Decode sel into a one-hot mask gated by in
  always_comb begin
    w_onehot = {NUM_WAYS{1'b0}};
    case (sel)
      3'd0:    w_onehot = {7'b0000000, in};
      3'd1:    w_onehot = {6'b000000, in, 1'b0};
      3'd2:    w_onehot = {5'b00000, in, 2'b00};
      3'd3:    w_onehot = {4'b0000, in, 3'b000};
      3'd4:    w_onehot = {3'b000, in, 4'b0000};
      3'd5:    w_onehot = {2'b00, in, 5'b00000};
      3'd6:    w_onehot = {1'b0, in, 6'b000000};
      3'd7:    w_onehot = {in, 7'b0000000};
      default: w_onehot = {NUM_WAYS{1'b0}};
    endcase
  end

  assign a = w_onehot[0];
  assign b = w_onehot[1];
  assign c = w_onehot[2];
  assign d = w_onehot[3];
  assign e = w_onehot[4];
  assign f = w_onehot[5];
  assign g = w_onehot[6];
  assign h = w_onehot[7];

endmodule

// File: rtl/dmux8way16_reg.sv
// Registered 8-way demultiplexer: parks one word per cycle in the slot chosen
// by sel, each slot with its own valid/ack handshake and a pending counter.
import dmux8way16_reg_pkg::*;

module dmux8way16_reg #(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  way_sel_t         sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output way_mask_t        out_valid,
  input  way_mask_t        out_ack,
  output way_cnt_t         pending
);

  logic [WIDTH-1:0] r_slot [NUM_WAYS];
  way_mask_t        r_valid;
  way_cnt_t         r_pending;

  logic             w_ready;
  logic             w_accept;
  way_mask_t        w_we;
  way_mask_t        w_consume;
  way_mask_t        w_valid_nxt;
  logic             w_fill;
  way_cnt_t         w_drop_cnt;
  way_cnt_t         w_pending_nxt;

  // A full slot can take a new word in the same cycle its consumer acks it,
  // so ready depends only on state, ack and sel, never on in_valid.
  assign w_ready  = ~r_valid[sel] | out_ack[sel];
  assign w_accept = in_valid & w_ready;

  dmux8way u_we_dec (
    .in  (w_accept),
    .sel (sel),
    .a   (w_we[0]),
    .b   (w_we[1]),
    .c   (w_we[2]),
    .d   (w_we[3]),
    .e   (w_we[4]),
    .f   (w_we[5]),
    .g   (w_we[6]),
    .h   (w_we[7])
  );

  // Next-state for valid flags and the pending counter
  always_comb begin
    w_consume     = r_valid & out_ack & ~w_we;
    w_valid_nxt   = (r_valid & ~w_consume) | w_we;
    w_fill        = |(w_we & ~r_valid);
    w_drop_cnt    = popcount_ways(w_consume);
    w_pending_nxt = r_pending + {{(CNT_W-1){1'b0}}, w_fill} - w_drop_cnt;
  end

  // Valid flags and pending counter; a rewrite on ack keeps the count level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= {NUM_WAYS{1'b0}};
      r_pending <= {CNT_W{1'b0}};
    end else begin
      r_valid   <= w_valid_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Slot data registers: load only on their own write enable, held on consume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        r_slot[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (w_we[i]) begin
          r_slot[i] <= in;
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign pending   = r_pending;

  assign a = r_slot[0];
  assign b = r_slot[1];
  assign c = r_slot[2];
  assign d = r_slot[3];
  assign e = r_slot[4];
  assign f = r_slot[5];
  assign g = r_slot[6];
  assign h = r_slot[7];

endmodule

// File: tb/tb_dmux8way16_reg.sv
// Directed self-checking bench for dmux8way16_reg.
module tb_dmux8way16_reg;

  logic        clk;
  logic        reset;
  logic [15:0] tb_in;
  logic [2:0]  tb_sel;
  logic        tb_in_valid;
  logic        tb_in_ready;
  logic [15:0] tb_a, tb_b, tb_c, tb_d, tb_e, tb_f, tb_g, tb_h;
  logic [7:0]  tb_out_valid;
  logic [7:0]  tb_out_ack;
  logic [3:0]  tb_pending;
  logic [15:0] slot_q [8];

  int total;
  int bad;

  dmux8way16_reg #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (tb_in),
    .sel       (tb_sel),
    .in_valid  (tb_in_valid),
    .in_ready  (tb_in_ready),
    .a         (tb_a),
    .b         (tb_b),
    .c         (tb_c),
    .d         (tb_d),
    .e         (tb_e),
    .f         (tb_f),
    .g         (tb_g),
    .h         (tb_h),
    .out_valid (tb_out_valid),
    .out_ack   (tb_out_ack),
    .pending   (tb_pending)
  );

  assign slot_q[0] = tb_a;
  assign slot_q[1] = tb_b;
  assign slot_q[2] = tb_c;
  assign slot_q[3] = tb_d;
  assign slot_q[4] = tb_e;
  assign slot_q[5] = tb_f;
  assign slot_q[6] = tb_g;
  assign slot_q[7] = tb_h;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    tb_in       = 16'h0000;
    tb_sel      = 3'd0;
    tb_in_valid = 1'b0;
    tb_out_ack  = 8'h00;

    // reset state
    #12;
    check("rst_valid", {24'h0, tb_out_valid}, 32'h0);
    check("rst_pending", {28'h0, tb_pending}, 32'h0);
    check("rst_ready", {31'h0, tb_in_ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tb_sel = 3'(i);
      #1;
      check($sformatf("idle_ready%0d", i), {31'h0, tb_in_ready}, 32'h1);
      check($sformatf("idle_slot%0d", i), {16'h0, slot_q[i]}, 32'h0);
    end
    tick();

    // single write to f, then consume
    tb_in = 16'h1234; tb_sel = 3'd5; tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    check("wr_f", {16'h0, tb_f}, 32'h1234);
    check("wr_valid", {24'h0, tb_out_valid}, 32'h20);
    check("wr_pending", {28'h0, tb_pending}, 32'h1);
    tb_out_ack = 8'h20;
    tick();
    tb_out_ack = 8'h00;
    check("ack_valid", {24'h0, tb_out_valid}, 32'h0);
    check("ack_pending", {28'h0, tb_pending}, 32'h0);
    check("ack_f_held", {16'h0, tb_f}, 32'h1234);

    // full-slot stall then accept on ack
    tb_in = 16'hAAAA; tb_sel = 3'd2; tb_in_valid = 1'b1;
    tick();
    tb_in = 16'hBBBB;
    #1;
    check("stall_ready", {31'h0, tb_in_ready}, 32'h0);
    tick();
    check("stall_c", {16'h0, tb_c}, 32'hAAAA);
    check("stall_valid", {24'h0, tb_out_valid}, 32'h04);
    tb_out_ack = 8'h04;
    #1;
    check("ackwr_ready", {31'h0, tb_in_ready}, 32'h1);
    tick();
    tb_in_valid = 1'b0;
    tb_out_ack  = 8'h00;
    check("ackwr_c", {16'h0, tb_c}, 32'hBBBB);
    check("ackwr_valid", {24'h0, tb_out_valid}, 32'h04);
    check("ackwr_pending", {28'h0, tb_pending}, 32'h1);
    tb_out_ack = 8'h04;
    tick();
    tb_out_ack = 8'h00;
    check("drain_c_valid", {24'h0, tb_out_valid}, 32'h0);

    // fill all eight slots
    for (int i = 0; i < 8; i++) begin
      tb_in = 16'(i); tb_sel = 3'(i); tb_in_valid = 1'b1;
      tick();
    end
    tb_in_valid = 1'b0;
    check("fill_valid", {24'h0, tb_out_valid}, 32'hFF);
    check("fill_pending", {28'h0, tb_pending}, 32'h8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_slot%0d", i), {16'h0, slot_q[i]}, i);
    end
    tb_out_ack = 8'hFF;
    tick();
    tb_out_ack = 8'h00;
    check("ackall_valid", {24'h0, tb_out_valid}, 32'h0);
    check("ackall_pending", {28'h0, tb_pending}, 32'h0);

    // spurious acks concurrent with consume and a write
    tb_in = 16'h0111; tb_sel = 3'd1; tb_in_valid = 1'b1;
    tick();
    tb_in = 16'h6666; tb_sel = 3'd6; tb_out_ack = 8'h0F;
    tick();
    tb_in_valid = 1'b0;
    tb_out_ack  = 8'h00;
    check("spur_valid", {24'h0, tb_out_valid}, 32'h40);
    check("spur_pending", {28'h0, tb_pending}, 32'h1);
    check("spur_g", {16'h0, tb_g}, 32'h6666);
    check("spur_b_held", {16'h0, tb_b}, 32'h0111);
    check("spur_a_held", {16'h0, tb_a}, 32'h0000);
    tb_out_ack = 8'h40;
    tick();
    tb_out_ack = 8'h00;

    // async reset mid-stream with slots 0 and 3 valid
    tb_in = 16'h00A0; tb_sel = 3'd0; tb_in_valid = 1'b1;
    tick();
    tb_in = 16'h03B0; tb_sel = 3'd3;
    tick();
    tb_in_valid = 1'b0;
    check("pre_rst_valid", {24'h0, tb_out_valid}, 32'h09);
    check("pre_rst_pending", {28'h0, tb_pending}, 32'h2);
    tb_in = 16'hDEAD; tb_sel = 3'd5; tb_in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {24'h0, tb_out_valid}, 32'h0);
    check("arst_pending", {28'h0, tb_pending}, 32'h0);
    check("arst_a", {16'h0, tb_a}, 32'h0);
    check("arst_d", {16'h0, tb_d}, 32'h0);
    tick();
    check("arst_f_dropped", {16'h0, tb_f}, 32'h0);
    check("arst_hold_valid", {24'h0, tb_out_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tb_in = 16'h5A5A; tb_sel = 3'd7; tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    check("post_rst_h", {16'h0, tb_h}, 32'h5A5A);
    check("post_rst_valid", {24'h0, tb_out_valid}, 32'h80);
    check("post_rst_pending", {28'h0, tb_pending}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
